// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster counters with registered sync, blank and colour outputs
module vga_timing_generator #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter bit H_SYNC_ACTIVE = 1'b0,
  parameter bit V_SYNC_ACTIVE = 1'b0,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixel_en,
  input  logic [3:0]               r_in,
  input  logic [3:0]               g_in,
  input  logic [3:0]               b_in,
  output logic [COUNTER_WIDTH-1:0] x,
  output logic [COUNTER_WIDTH-1:0] y,
  output logic [3:0]               r,
  output logic [3:0]               g,
  output logic [3:0]               b,
  output logic                     horizontal_sync,
  output logic                     vertical_sync,
  output logic                     video_output,
  output logic                     frame_done
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW = COUNTER_WIDTH;
  logic [CW-1:0] h, v;
  logic h_end, v_end, active, hs_on, vs_on;
  always_comb begin
    h_end  = h == CW'(H_TOTAL - 1);
    v_end  = v == CW'(V_TOTAL - 1);
    active = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
    hs_on  = (h >= CW'(H_ACTIVE + H_FRONT)) && (h < CW'(H_ACTIVE + H_FRONT + H_SYNC));
    vs_on  = (v >= CW'(V_ACTIVE + V_FRONT)) && (v < CW'(V_ACTIVE + V_FRONT + V_SYNC));
  end
  assign x = h;
  assign y = v;
  // Outputs decode the pre-edge counter, so they trail x/y by one pixel tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h               <= '0;
      v               <= '0;
      video_output    <= 1'b0;
      {r, g, b}       <= 12'h0;
      horizontal_sync <= ~H_SYNC_ACTIVE;
      vertical_sync   <= ~V_SYNC_ACTIVE;
      frame_done      <= 1'b0;
    end else if (pixel_en) begin
      h               <= h_end ? '0 : h + 1'b1;
      v               <= h_end ? (v_end ? '0 : v + 1'b1) : v;
      video_output    <= active;
      {r, g, b}       <= active ? {r_in, g_in, b_in} : 12'h0;
      horizontal_sync <= hs_on ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
      vertical_sync   <= vs_on ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
      frame_done      <= h_end && v_end;
    end else begin
      frame_done      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: randomized bench against a tick-count raster model
module tb_vga_timing_generator;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0, pixel_en = 1'b0;
  logic [3:0] r_in = '0, g_in = '0, b_in = '0;
  logic [9:0] x, y;
  logic [3:0] r, g, b;
  logic hsync, vsync, video_output, frame_done;
  int n = 0, pass_cnt = 0, total = 0, cyc = 0, last_fd = -1, exp_period = 0, salt = 1;
  bit force_white = 1'b1;
  logic e_vid, e_hs, e_vs, e_fd;
  logic [11:0] e_col;

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_ACTIVE(1'b0), .V_SYNC_ACTIVE(1'b0), .COUNTER_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .r(r), .g(g), .b(b),
    .horizontal_sync(hsync), .vertical_sync(vsync),
    .video_output(video_output), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] colour(int h, int v);
    logic [11:0] c;
    c = force_white ? 12'hFFF : 12'(h * salt + v * 7 + (h ^ v) * 13 + h * v * 41);
    return c;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  // The model tracks pixel ticks since reset; position in the frame follows by division
  task automatic tick(bit rn, bit pe);
    int p, h, v;
    logic [11:0] c;
    p = n % FT;
    h = p % HT;
    v = p / HT;
    c = colour(h, v);
    rst_n = rn;
    pixel_en = pe;
    {r_in, g_in, b_in} = c;
    @(posedge clk);
    #1;
    cyc++;
    if (!rn) begin
      n = 0; e_vid = 0; e_hs = 1; e_vs = 1; e_col = 12'h0; e_fd = 0;
    end else if (pe) begin
      e_vid = (h < HA) && (v < VA);
      e_hs  = !(h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(v >= VA + VF && v < VA + VF + VS);
      e_col = e_vid ? c : 12'h0;
      e_fd  = (p == FT - 1);
      n++;
    end else begin
      e_fd = 0;
    end
    p = n % FT;
    chk("x", 32'(x), 32'(p % HT));
    chk("y", 32'(y), 32'(p / HT));
    chk("video_output", 32'(video_output), 32'(e_vid));
    chk("horizontal_sync", 32'(hsync), 32'(e_hs));
    chk("vertical_sync", 32'(vsync), 32'(e_vs));
    chk("r", 32'(r), 32'(e_col[11:8]));
    chk("g", 32'(g), 32'(e_col[7:4]));
    chk("b", 32'(b), 32'(e_col[3:0]));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (exp_period > 0 && frame_done === 1'b1) begin
      if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(exp_period));
      last_fd = cyc;
    end
  endtask

  initial begin
    salt = int'($urandom_range(1, 15));
    repeat (3) tick(1'b0, 1'b1);
    exp_period = FT;
    last_fd = -1;
    repeat (FT) tick(1'b1, 1'b1);
    force_white = 1'b0;
    repeat (FT + 5) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    exp_period = 2 * FT;
    last_fd = -1;
    for (int i = 0; i < 4 * FT + 4; i++) tick(1'b1, i % 2 == 0);
    exp_period = 0;
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < FT && (n % FT) % HT != HA + HF + 1; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    repeat (HT + 3) tick(1'b1, 1'b1);
    for (int i = 0; i < FT && (n % FT) != (VA + VF) * HT + 3; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    repeat (2 * HT) tick(1'b1, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates VGA raster timing and drives the colour/sync/blank signals consumed by the VGA output adapter. Owns the horizontal and vertical pixel counters and exposes the current coordinate to the renderer. Registers the renderer's 4-bit-per-channel colour aligned with the syncs and forces it to zero outside the visible area. Defaults are 640x480@60 with a 25 MHz pixel rate. Faster system clocks are supported through a pixel-enable strobe.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_ACTIVE, 0, asserted level of horizontal_sync
- V_SYNC_ACTIVE, 0, asserted level of vertical_sync
- COUNTER_WIDTH, 10, width of counters and x/y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  single clock for all logic
- rst_n  input  1  synchronous, active-low reset
- pixel_en  input  1  pixel tick; all state advances only on clk edges where pixel_en=1
- r_in, g_in, b_in  input  4 each  renderer colour for the current x/y
- x  output  COUNTER_WIDTH  current horizontal counter
- y  output  COUNTER_WIDTH  current vertical counter
- r, g, b  output  4 each  registered, blanked colour
- horizontal_sync  output  1  registered horizontal sync
- vertical_sync  output  1  registered vertical sync
- video_output  output  1  registered active-video flag; high = visible pixel
- frame_done  output  1  one-clk pulse after the counter wraps to (0,0)

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800)
- V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525)

Counters (h, v), updated on each edge with rst_n=1 and pixel_en=1:
- Normal step: h <= h+1.
- If h = H_TOTAL-1: h <= 0 and v <= v+1.
- If also v = V_TOTAL-1: v <= 0.
- x = h and y = v, driven directly from the counter registers.

Output stage, same enable; every output reflects the counter value held *before* that edge:
- video_output <= (h < H_ACTIVE) && (v < V_ACTIVE).
- horizontal_sync <= H_SYNC_ACTIVE when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751); otherwise the inverse level.
- vertical_sync <= V_SYNC_ACTIVE when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491); otherwise the inverse level. The decode uses v only, so vertical sync spans whole lines.
- r/g/b <= r_in/g_in/b_in while the active condition holds, otherwise 4'h0.

frame_done:
- Registered.
- Set to 1 on an edge where pixel_en=1, h = H_TOTAL-1 and v = V_TOTAL-1.
- Cleared on every other edge, so it is exactly one clk wide whatever the pixel_en pattern.

Renderer contract:
- r_in/g_in/b_in must be a function of the current x/y.
- They are sampled on the same edge that advances the counter.

pixel_en=0: all registers hold their value.

## Timing
Reset (rst_n=0 at a clk edge, overrides pixel_en):
- h=v=0, so x=y=0
- video_output=0
- r=g=b=0
- horizontal_sync=!H_SYNC_ACTIVE, vertical_sync=!V_SYNC_ACTIVE
- frame_done=0

Latency:
- Outputs lag the counter by exactly one pixel tick.
- The colour for coordinate (x,y) appears on r/g/b one pixel tick after x/y shows that value.

Reset behaviour:
- Reset mid-frame takes effect at the next edge, including during sync pulses.
- The first pixel tick after release outputs the decode of (0,0): video_output=1 and x becomes 1.

Periods with pixel_en always 1:
- Line period 800 clk.
- Frame period 420000 clk.
- horizontal_sync active for 96 consecutive clk per line.
- vertical_sync active for 1600 consecutive clk per frame.

## Test plan
- Reset: rst_n=0 for 3 clk with pixel_en=1 and r_in=4'hF → x=y=0, r=g=b=0, video_output=0, horizontal_sync=vertical_sync=1, frame_done=0.
- Line timing, pixel_en=1:
  - video_output high for 640 consecutive clk, then low for 160.
  - horizontal_sync low for exactly 96 clk, starting 16 clk after video_output falls.
  - Line period 800.
- Frame timing:
  - vertical_sync low for exactly 1600 clk, starting at line 490.
  - video_output never high while the output corresponds to y ≥ 480.
  - frame_done high exactly 1 clk every 420000 clk.
- Blanking/alignment:
  - Constant r_in=g_in=b_in=4'hF → r=4'hF only while video_output=1, else 0.
  - r_in=x[3:0] → r at tick k equals x[3:0] of tick k-1.
- Clock enable: pixel_en toggling 1,0,1,0 → all durations double (line 1600 clk); outputs stable on pixel_en=0 cycles; frame_done still 1 clk wide.
- Mid-sync reset: rst_n=0 for 1 clk while h=700 → next cycle horizontal_sync=1 and x=y=0; after release the first video_output=1 is paired with the colour for (0,0).
